fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Two-port arbiter that shares the single-ported 16-bit framebuffer SRAM between the video scanout fetcher and the CPU bus. It accepts one request per cycle from either requester, drives the framebuffer's address, write-data and write-strobe inputs from registers, and returns read data to the winning requester. It sits directly in front of the framebuffer SRAM interface block, which performs one access per CLK cycle.

## Interface
- STARVE_LIMIT, 4, maximum consecutive video grants while a CPU request is pending; range 1..15.
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- vid_req  in  1  video read request; held with vid_addr until acked.
- vid_addr  in  16  video read word address.
- vid_ack  out  1  combinational; request accepted at this rising edge.
- vid_rdata  out  16  registered video read data.
- vid_rvalid  out  1  one-cycle pulse; vid_rdata valid.
- cpu_req  in  1  CPU request; held with cpu_we/cpu_addr/cpu_wdata until acked.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_ack  out  1  combinational; request accepted at this rising edge.
- cpu_rdata  out  16  registered CPU read data.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid (reads only).
- mem_address  out  16  to framebuffer address.
- mem_dataIn  out  16  to framebuffer dataIn.
- mem_write  out  1  to framebuffer write.
- mem_dataOut  in  16  from framebuffer dataOut.

## Operation
- Grant decided combinationally each cycle from vid_req, cpu_req, and the starvation counter; at most one of vid_ack/cpu_ack high.
- Default priority: video over CPU. Both idle: no ack.
- Access state register: IDLE, VID, CPU. On the edge where an ack is high, state becomes VID or CPU and mem_address/mem_dataIn/mem_write are loaded (mem_write = cpu_we for CPU, 0 for VID); otherwise state becomes IDLE, mem_write clears, and mem_address/mem_dataIn hold.
- At the end of a VID or CPU-read cycle, mem_dataOut is captured into vid_rdata or cpu_rdata and the matching rvalid pulses for one cycle; the other rdata register holds.
- CPU writes produce no rvalid.
- Starvation counter (see Configuration): width 4, counts cycles where cpu_req=1 and vid_ack=1; clears on cpu_ack or when cpu_req=0; while counter == STARVE_LIMIT, CPU wins over video.
- Back-to-back requests from the same or different requesters are accepted every cycle, so sustained throughput is one access per cycle.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Request accepted at edge t (ack high in cycle t-1→t window): memory access occupies cycle t..t+1; rdata and rvalid are visible in cycle t+1..t+2 (read latency 2 edges from ack).
- Write at cycle k followed by a read of the same address at cycle k+1 returns the new data.
- Reset asserted mid-access: the in-flight access is dropped, no rvalid is issued, and mem_write clears immediately (asynchronously).
- Requesters dropping req without an ack is legal; no state is retained.

## Configuration
- FB_ARB_STARVE_EN defined: the starvation counter is built, and the CPU is guaranteed a grant after at most STARVE_LIMIT consecutive contended video grants.
- Not defined: no counter; strict video priority, and the CPU may starve indefinitely.

## Test plan
- Reset: RST_N=0 with vid_req=cpu_req=1 → all outputs 0; after release, vid_ack=1 in the first cycle.
- CPU write then read: write 0x1234 @0x0040, then read @0x0040 on the next cycle → mem_write=1 for one cycle, then cpu_rvalid=1 with cpu_rdata=0x1234 two edges after the read ack.
- Video stream: vid_req held with addresses 0x0000..0x0007 → eight consecutive vid_ack, eight consecutive vid_rvalid pulses in order with 2-edge latency.
- Contention with FB_ARB_STARVE_EN and STARVE_LIMIT=4: vid_req and cpu_req held continuously → pattern of 4 vid_ack followed by 1 cpu_ack, repeating.
- Contention without the macro: the same stimulus → cpu_ack never asserts while vid_req=1.
- Reset mid-read: assert RST_N=0 one cycle after a vid_ack → vid_rvalid never pulses, and mem_write=0.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter: two-port arbiter that shares the single-ported 16-bit framebuffer
// SRAM between the video scanout fetcher and the CPU bus. Grants are decided
// combinationally, the SRAM address/data/strobe are driven from registers, and
// read data returns two edges after the ack.
// Optional feature: define FB_ARB_STARVE_EN to build the CPU starvation counter.
// Without it, video has strict priority and the CPU may starve.

module fb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,
    output logic        vid_rvalid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic [15:0] mem_address,
    output logic [15:0] mem_dataIn,
    output logic        mem_write,
    input  logic [15:0] mem_dataOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] mem_address_q;
    logic [15:0] mem_dataIn_q;
    logic        mem_write_q;
    logic [15:0] vid_rdata_q;
    logic        vid_rvalid_q;
    logic [15:0] cpu_rdata_q;
    logic        cpu_rvalid_q;
    logic        starve;

    // The counter is four bits wide, so the limit must fit and be reachable.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("fb_arbiter: STARVE_LIMIT must be in 1..15");
    end

`ifdef FB_ARB_STARVE_EN
    logic [3:0] starve_q;
    logic [3:0] starve_d;

    assign starve = (starve_q == 4'(STARVE_LIMIT));

    // Count video wins over a waiting CPU; any CPU grant or idle CPU restarts it.
    always_comb begin
        starve_d = starve_q;
        if (!cpu_req || cpu_ack) begin
            starve_d = 4'd0;
        end else if (vid_ack) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve = 1'b0;
`endif

    // Grants are masked during reset so every output reads 0 while RST_N is low.
    assign vid_ack = RST_N & vid_req & ~(starve & cpu_req);
    assign cpu_ack = RST_N & cpu_req & (~vid_req | starve);

    // Access state, SRAM drive registers and read-data return in one FSM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            mem_address_q <= 16'h0000;
            mem_dataIn_q  <= 16'h0000;
            mem_write_q   <= 1'b0;
            vid_rdata_q   <= 16'h0000;
            vid_rvalid_q  <= 1'b0;
            cpu_rdata_q   <= 16'h0000;
            cpu_rvalid_q  <= 1'b0;
        end else begin
            if (vid_ack) begin
                state_q       <= VID;
                mem_address_q <= vid_addr;
                mem_write_q   <= 1'b0;
            end else if (cpu_ack) begin
                state_q       <= CPU;
                mem_address_q <= cpu_addr;
                mem_dataIn_q  <= cpu_wdata;
                mem_write_q   <= cpu_we;
            end else begin
                state_q       <= IDLE;
                mem_write_q   <= 1'b0;
            end

            vid_rvalid_q <= (state_q == VID);
            if (state_q == VID) begin
                vid_rdata_q <= mem_dataOut;
            end

            cpu_rvalid_q <= (state_q == CPU) && !mem_write_q;
            if ((state_q == CPU) && !mem_write_q) begin
                cpu_rdata_q <= mem_dataOut;
            end
        end
    end

    assign mem_address = mem_address_q;
    assign mem_dataIn  = mem_dataIn_q;
    assign mem_write   = mem_write_q;
    assign vid_rdata   = vid_rdata_q;
    assign vid_rvalid  = vid_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_rvalid  = cpu_rvalid_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Testbench for fb_arbiter with a behavioural framebuffer model
// (combinational read, write on the clock edge while mem_write is high).
// Contention expectations follow FB_ARB_STARVE_EN when it is defined.

module tb_fb_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        vid_rvalid;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic [15:0] mem_address;
    logic [15:0] mem_dataIn;
    logic        mem_write;
    logic [15:0] mem_dataOut;

    logic [15:0] fbMem [0:65535];

    int errorCount = 0;
    int checkCount = 0;

    fb_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_ack     (vid_ack),
        .vid_rdata   (vid_rdata),
        .vid_rvalid  (vid_rvalid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .mem_address (mem_address),
        .mem_dataIn  (mem_dataIn),
        .mem_write   (mem_write),
        .mem_dataOut (mem_dataOut)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Framebuffer model: asynchronous read, synchronous write.
    always @(posedge CLK) begin
        if (mem_write) begin
            fbMem[mem_address] <= mem_dataIn;
        end
    end
    assign mem_dataOut = fbMem[mem_address];

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic vReq, input logic [15:0] vAddr, input logic cReq,
                                 input logic cWe, input logic [15:0] cAddr, input logic [15:0] cWdata);
        vid_req   = vReq;
        vid_addr  = vAddr;
        cpu_req   = cReq;
        cpu_we    = cWe;
        cpu_addr  = cAddr;
        cpu_wdata = cWdata;
    endtask

    // Advance to 2 ns after the next rising edge, where inputs are driven.
    task automatic nextCycle();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            fbMem[i] = 16'(i) ^ 16'hA5A5;
        end

        // Reset with both requesters asking.
        RST_N = 1'b0;
        applyStimulus(1'b1, 16'h0003, 1'b1, 1'b1, 16'h0011, 16'hBEEF);
        nextCycle();
        nextCycle();
        #2;
        checkOutput("rst_vid_ack", 16'(vid_ack), 16'd0);
        checkOutput("rst_cpu_ack", 16'(cpu_ack), 16'd0);
        checkOutput("rst_vid_rvalid", 16'(vid_rvalid), 16'd0);
        checkOutput("rst_cpu_rvalid", 16'(cpu_rvalid), 16'd0);
        checkOutput("rst_mem_write", 16'(mem_write), 16'd0);
        checkOutput("rst_mem_address", mem_address, 16'h0000);
        checkOutput("rst_mem_dataIn", mem_dataIn, 16'h0000);
        checkOutput("rst_vid_rdata", vid_rdata, 16'h0000);
        checkOutput("rst_cpu_rdata", cpu_rdata, 16'h0000);
        RST_N = 1'b1;
        #1;
        checkOutput("rel_vid_ack", 16'(vid_ack), 16'd1);
        checkOutput("rel_cpu_ack", 16'(cpu_ack), 16'd0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) nextCycle();

        // CPU write then read of the same address.
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h1234);
        #2;
        checkOutput("wr_cpu_ack", 16'(cpu_ack), 16'd1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
        #2;
        checkOutput("wr_mem_write", 16'(mem_write), 16'd1);
        checkOutput("wr_mem_address", mem_address, 16'h0040);
        checkOutput("wr_mem_dataIn", mem_dataIn, 16'h1234);
        checkOutput("rd_cpu_ack", 16'(cpu_ack), 16'd1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #2;
        checkOutput("rd_mem_write", 16'(mem_write), 16'd0);
        checkOutput("wr_no_rvalid", 16'(cpu_rvalid), 16'd0);
        nextCycle();
        #2;
        checkOutput("rd_cpu_rvalid", 16'(cpu_rvalid), 16'd1);
        checkOutput("rd_cpu_rdata", cpu_rdata, 16'h1234);
        nextCycle();
        #2;
        checkOutput("rd_rvalid_pulse", 16'(cpu_rvalid), 16'd0);
        repeat (2) nextCycle();

        // Video stream 0x0000..0x0007, data returns two edges after each ack.
        for (int j = 0; j < 11; j++) begin
            applyStimulus(j < 8, 16'(j), 1'b0, 1'b0, 16'h0000, 16'h0000);
            #2;
            checkOutput($sformatf("vs_ack_%0d", j), 16'(vid_ack), 16'(j < 8));
            if (j >= 2 && j < 10) begin
                checkOutput($sformatf("vs_rvalid_%0d", j), 16'(vid_rvalid), 16'd1);
                checkOutput($sformatf("vs_rdata_%0d", j), vid_rdata, 16'(j - 2) ^ 16'hA5A5);
            end else begin
                checkOutput($sformatf("vs_rvalid_%0d", j), 16'(vid_rvalid), 16'd0);
            end
            nextCycle();
        end
        repeat (2) nextCycle();

        // Contention: both requesters held continuously.
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b1, 16'(k), 1'b1, 1'b0, 16'h0100, 16'h0000);
            #2;
`ifdef FB_ARB_STARVE_EN
            checkOutput($sformatf("ct_vid_ack_%0d", k), 16'(vid_ack), 16'((k % 5) != 4));
            checkOutput($sformatf("ct_cpu_ack_%0d", k), 16'(cpu_ack), 16'((k % 5) == 4));
`else
            checkOutput($sformatf("ct_vid_ack_%0d", k), 16'(vid_ack), 16'd1);
            checkOutput($sformatf("ct_cpu_ack_%0d", k), 16'(cpu_ack), 16'd0);
`endif
            nextCycle();
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) nextCycle();

        // Reset during a CPU write clears the strobe immediately.
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0080, 16'h5555);
        #2;
        checkOutput("rw_cpu_ack", 16'(cpu_ack), 16'd1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        checkOutput("rw_mem_write_pre", 16'(mem_write), 16'd1);
        RST_N = 1'b0;
        #1;
        checkOutput("rw_mem_write_rst", 16'(mem_write), 16'd0);
        checkOutput("rw_mem_address_rst", mem_address, 16'h0000);
        nextCycle();
        RST_N = 1'b1;
        nextCycle();

        // Reset one cycle after a video ack drops the read.
        applyStimulus(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #2;
        checkOutput("rv_vid_ack", 16'(vid_ack), 16'd1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        RST_N = 1'b0;
        #1;
        checkOutput("rv_mem_write", 16'(mem_write), 16'd0);
        checkOutput("rv_rvalid_0", 16'(vid_rvalid), 16'd0);
        nextCycle();
        #2;
        checkOutput("rv_rvalid_1", 16'(vid_rvalid), 16'd0);
        RST_N = 1'b1;
        nextCycle();
        #2;
        checkOutput("rv_rvalid_2", 16'(vid_rvalid), 16'd0);
        checkOutput("rv_vid_rdata", vid_rdata, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
